ps2_device_tx: RTL and testbench
================================

Name: ps2_device_tx

Overview:
- PS/2 device-side transmitter: the keyboard end of the PS/2 link that ps2_keyboard receives.
- Serialises queued scancode bytes onto ps2_clk/ps2_data as standard 11-bit frames.
- Used in simulation and on-board loopback to drive the ps2_keyboard receiver without a physical keyboard.
- Contains a small byte FIFO so a scancode sequence can be queued in one burst, for example 0xF0 followed by 0x1C.

Parameters:
- CLK_DIV, 25, system clocks per PS/2 clock half-period; must be at least 2.
- FIFO_DEPTH, 8, bytes of queue; must be a power of 2.
- IDLE_GAP, 50, system clocks of idle (clk=1, data=1) enforced after every frame.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- wr_en  input  1  push wr_data into the FIFO this cycle.
- wr_data  input  8  scancode byte to queue.
- full  output  1  FIFO holds FIFO_DEPTH bytes.
- empty  output  1  FIFO holds 0 bytes.
- overflow  output  1  sticky flag: a write was dropped while full.
- busy  output  1  high from the frame-start cycle through the end of IDLE_GAP.
- frame_done  output  1  one-cycle pulse when the stop bit completes.
- ps2_clk  output  1  PS/2 clock line as the device drives it; idle high.
- ps2_data  output  1  PS/2 data line; idle high.

Behaviour:
- Reset (asynchronous, resetn=0):
  - FIFO is empty: empty=1, full=0.
  - overflow=0, busy=0, frame_done=0.
  - ps2_clk=1, ps2_data=1.
  - FSM goes to IDLE and all counters clear.
- FIFO:
  - Write is accepted when wr_en=1 and either full=0 or a pop occurs in the same cycle.
  - A write attempted while full with no pop is dropped and sets overflow until reset.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - full and empty are registered and update the cycle after a push or pop.
- FSM states:
  - IDLE:
    - Outputs held high.
    - If empty=0, pop the head byte, latch it into the shift register, compute odd parity (parity = ~^byte), and go to SHIFT.
    - Minimum latency from a write into an empty FIFO to ps2_data falling: 2 cycles (FIFO register, then IDLE pop).
  - SHIFT:
    - Sends 11 bits in order: start 0, data[0] through data[7] (LSB first), parity, stop 1.
    - Each bit occupies exactly 2*CLK_DIV cycles with ps2_data held constant.
    - ps2_clk is 1 for the first CLK_DIV cycles of each bit and 0 for the second CLK_DIV cycles.
    - The receiver therefore samples on the falling edge, in mid-bit; data changes only while ps2_clk is high.
    - After the stop bit's low half: ps2_clk returns to 1, frame_done pulses for 1 cycle, go to GAP.
    - Frame length is 22*CLK_DIV cycles.
  - GAP:
    - Lines held high for IDLE_GAP cycles, then go to IDLE.
    - Back-to-back queued bytes are therefore separated by exactly IDLE_GAP+1 cycles, counting the IDLE pop cycle.
- busy is 1 in SHIFT and GAP, 0 in IDLE.
- Reset asserted mid-frame aborts immediately: lines go high, the partial byte and queued bytes are discarded, and no frame_done is issued.
- Half-period counter: width $clog2(CLK_DIV); bit counter: 0..10. Both wrap only under FSM control and never free-run.

Optional Feature:
- Macro: PS2_TX_INHIBIT_EN.
- With the macro defined:
  - Adds input port host_inhibit (1 bit), meaning the host is pulling the clock line low.
  - While in IDLE with host_inhibit=1, no pop occurs.
  - If host_inhibit rises during SHIFT before the parity bit starts:
    - The frame aborts and lines go high.
    - The byte is kept in a retry register.
    - The FSM returns to IDLE and resends that byte before any further pop once host_inhibit=0.
    - No frame_done is issued for the aborted frame.
  - If host_inhibit rises during the parity or stop bit, the frame completes normally.
- Without the macro: there is no host_inhibit port, and the block behaves as if it were tied to 0.

Test Plan:
- Reset then single byte:
  - Setup: CLK_DIV=4; write 0x1C.
  - Required: ps2_data bit sequence 0,0,0,1,1,1,0,0,0,0,1 (parity 0), each bit lasting 8 cycles.
  - Required: 11 ps2_clk falling edges, frame_done once, 88 cycles of SHIFT; the ps2_keyboard receiver captures 0x1C.
- Parity:
  - Write 0x00: parity bit 1.
  - Write 0xFF: parity bit 1.
  - Write 0x01: parity bit 0.
- Burst:
  - Stimulus: write 0xF0 then 0x1C on consecutive cycles.
  - Required: two frames in order, and the gap between the end of the first stop bit and the start of the second start bit is IDLE_GAP+1 cycles.
- Overflow:
  - Setup: FIFO_DEPTH=8; hold transmission busy; issue 9 writes.
  - Required: full=1 after 8 writes, overflow=1 after the 9th, and exactly 8 frames are transmitted.
- Reset mid-frame:
  - Stimulus: assert resetn=0 during data bit 4.
  - Required: ps2_clk and ps2_data go to 1 asynchronously, empty=1, no frame_done, and a clean new frame follows the next write.
- Inhibit (PS2_TX_INHIBIT_EN):
  - Stimulus: assert host_inhibit during data bit 2 of 0x5A.
  - Required: the frame aborts; after release, a complete 0x5A frame is sent with parity 1.

Source files
------------

// File: rtl/ps2_device_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_device_tx
// Purpose  : Device-side (keyboard end) PS/2 transmitter. Bytes pushed into
//            a small FIFO are sent as 11-bit frames (start 0, 8 data bits
//            LSB first, odd parity, stop 1). Each bit lasts 2*CLK_DIV
//            system clocks: ps2_clk is high for the first half and low for
//            the second, so data changes only while ps2_clk is high. Every
//            frame is followed by IDLE_GAP clocks with both lines high.
// Ports    : clk, resetn (async, active-low)
//            wr_en, wr_data[7:0]          - FIFO push
//            full, empty, overflow        - FIFO status (overflow sticky)
//            busy, frame_done             - transmitter status
//            ps2_clk, ps2_data            - PS/2 lines as driven, idle high
//            host_inhibit                 - only with PS2_TX_INHIBIT_EN
// Options  : `define PS2_TX_INHIBIT_EN adds host_inhibit; a frame interrupted
//            before its parity bit is retried before any further pop.
// Params   : CLK_DIV >= 2, FIFO_DEPTH power of 2 (>= 2), IDLE_GAP >= 1.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_device_tx #(
  parameter int CLK_DIV    = 25,
  parameter int FIFO_DEPTH = 8,
  parameter int IDLE_GAP   = 50
) (
  input  logic       clk,
  input  logic       resetn,
`ifdef PS2_TX_INHIBIT_EN
  input  logic       host_inhibit,
`endif
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  output logic       frame_done,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int c_addr_w     = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w      = c_addr_w + 1;
  localparam int c_half_w     = $clog2(CLK_DIV);
  localparam int c_gap_w      = $clog2(IDLE_GAP + 1);
  localparam int c_half_last_i = CLK_DIV - 1;
  localparam int c_gap_last_i  = IDLE_GAP - 1;

  localparam logic [c_cnt_w-1:0]  c_depth     = FIFO_DEPTH[c_cnt_w-1:0];
  localparam logic [c_half_w-1:0] c_half_last = c_half_last_i[c_half_w-1:0];
  localparam logic [c_gap_w-1:0]  c_gap_last  = c_gap_last_i[c_gap_w-1:0];
  localparam logic [3:0]          c_last_bit  = 4'd10;
  localparam logic [3:0]          c_par_bit   = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // FIFO storage and status
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic [c_cnt_w-1:0]  w_count_nxt;
  logic                r_full;
  logic                r_empty;
  logic                r_overflow;

  // Transmitter state
  state_t              r_state;
  logic [c_half_w-1:0] r_half_cnt;
  logic                r_low_half;
  logic [3:0]          r_bit;
  logic [c_gap_w-1:0]  r_gap_cnt;
  logic [9:0]          r_shift;     // {stop, parity, data} still to send
  logic                r_ps2_clk;
  logic                r_ps2_data;
  logic                r_busy;
  logic                r_frame_done;

  logic                w_pop;
  logic                w_push;
  logic                w_start;
  logic [7:0]          w_start_byte;
  logic [7:0]          w_head;

  assign w_head = r_mem[r_rd_ptr];

`ifdef PS2_TX_INHIBIT_EN
  logic       r_retry_valid;
  logic [7:0] r_retry_byte;   // byte of the frame in flight, resent on abort
  logic       w_retry_go;

  // A pending retry blocks the FIFO so the interrupted byte keeps its order.
  assign w_pop        = (r_state == ST_IDLE) && !r_empty && !host_inhibit && !r_retry_valid;
  assign w_retry_go   = (r_state == ST_IDLE) && r_retry_valid && !host_inhibit;
  assign w_start      = w_pop || w_retry_go;
  assign w_start_byte = r_retry_valid ? r_retry_byte : w_head;
`else
  assign w_pop        = (r_state == ST_IDLE) && !r_empty;
  assign w_start      = w_pop;
  assign w_start_byte = w_head;
`endif

  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign w_push = wr_en && (!r_full || w_pop);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_cnt_w'(1);
      2'b01:   w_count_nxt = r_count - c_cnt_w'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == c_depth);
      r_empty    <= (w_count_nxt == '0);
      r_overflow <= r_overflow || (wr_en && !w_push);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_half_cnt    <= '0;
      r_low_half    <= 1'b0;
      r_bit         <= '0;
      r_gap_cnt     <= '0;
      r_shift       <= '0;
      r_ps2_clk     <= 1'b1;
      r_ps2_data    <= 1'b1;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
`ifdef PS2_TX_INHIBIT_EN
      r_retry_valid <= 1'b0;
      r_retry_byte  <= '0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ps2_clk  <= 1'b1;
          r_ps2_data <= 1'b1;
          if (w_start) begin
            // Start bit goes out on the pop edge itself.
            r_shift    <= {1'b1, ~^w_start_byte, w_start_byte};
            r_ps2_data <= 1'b0;
            r_half_cnt <= '0;
            r_low_half <= 1'b0;
            r_bit      <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_SHIFT;
`ifdef PS2_TX_INHIBIT_EN
            r_retry_byte  <= w_start_byte;
            r_retry_valid <= 1'b0;
`endif
          end
        end

        ST_SHIFT: begin
`ifdef PS2_TX_INHIBIT_EN
          if (host_inhibit && (r_bit < c_par_bit)) begin
            r_ps2_clk     <= 1'b1;
            r_ps2_data    <= 1'b1;
            r_busy        <= 1'b0;
            r_retry_valid <= 1'b1;
            r_state       <= ST_IDLE;
          end else
`endif
          if (r_half_cnt == c_half_last) begin
            r_half_cnt <= '0;
            if (!r_low_half) begin
              r_low_half <= 1'b1;
              r_ps2_clk  <= 1'b0;
            end else begin
              r_low_half <= 1'b0;
              r_ps2_clk  <= 1'b1;
              if (r_bit == c_last_bit) begin
                r_ps2_data   <= 1'b1;
                r_frame_done <= 1'b1;
                r_gap_cnt    <= '0;
                r_state      <= ST_GAP;
              end else begin
                r_bit      <= r_bit + 4'd1;
                r_ps2_data <= r_shift[0];
                r_shift    <= {1'b1, r_shift[9:1]};
              end
            end
          end else begin
            r_half_cnt <= r_half_cnt + c_half_w'(1);
          end
        end

        ST_GAP: begin
          r_ps2_clk  <= 1'b1;
          r_ps2_data <= 1'b1;
          if (r_gap_cnt == c_gap_last) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
          end
        end

        default: begin
          r_ps2_clk  <= 1'b1;
          r_ps2_data <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign full       = r_full;
  assign empty      = r_empty;
  assign overflow   = r_overflow;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign ps2_clk    = r_ps2_clk;
  assign ps2_data   = r_ps2_data;

endmodule
`default_nettype wire

// File: tb/tb_ps2_device_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_device_tx
// Purpose  : Self-checking bench for ps2_device_tx. A line-level decoder
//            reconstructs bytes from ps2_clk/ps2_data; expected frames are
//            built from the byte value and odd-parity rule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_device_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int IDLE_GAP   = 10;
  localparam int BIT_CYC    = 2 * CLK_DIV;
  localparam int FRAME_CYC  = 22 * CLK_DIV;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, busy, frame_done, ps2_clk, ps2_data;
`ifdef PS2_TX_INHIBIT_EN
  logic       host_inhibit = 1'b0;
`endif

  ps2_device_tx #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH),
    .IDLE_GAP  (IDLE_GAP)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
`ifdef PS2_TX_INHIBIT_EN
    .host_inhibit(host_inhibit),
`endif
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .busy        (busy),
    .frame_done  (frame_done),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Line decoder state (written only by the monitor process)
  int   cyc = 0;
  int   fall_cnt = 0;
  int   fd_cnt = 0;
  int   rx_err = 0;
  logic [7:0] q_rx[$];
  int   q_start[$];
  int   q_fd[$];

  initial begin : monitor
    logic       prev_clk;
    logic       prev_data;
    logic       in_frame;
    int         nbits;
    logic [10:0] sh;
    prev_clk = 1'b1; prev_data = 1'b1; in_frame = 1'b0; nbits = 0; sh = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        in_frame = 1'b0; nbits = 0; prev_clk = 1'b1; prev_data = 1'b1;
      end else begin
        if (frame_done === 1'b1) begin
          fd_cnt++;
          q_fd.push_back(cyc);
        end
        if (!in_frame && prev_data && !ps2_data && ps2_clk) begin
          in_frame = 1'b1; nbits = 0;
          q_start.push_back(cyc);
        end
        if (in_frame && prev_clk && !ps2_clk) begin
          fall_cnt++;
          sh[nbits] = ps2_data;
          nbits++;
          if (nbits == 11) begin
            in_frame = 1'b0;
            if (sh[0] !== 1'b0 || sh[10] !== 1'b1 || (^sh[9:1]) !== 1'b1) rx_err++;
            q_rx.push_back(sh[8:1]);
          end
        end
        prev_clk = ps2_clk; prev_data = ps2_data;
      end
    end
  end

  // Expected frame: index 0 is the start bit, sent first.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (n < budget && !(busy === 1'b0 && empty === 1'b1)) begin
      tick();
      n++;
    end
    chk({tag, "_idle_timeout"}, (n < budget), 1);
  endtask

  // Follows one frame from its first start-bit cycle through the idle gap.
  task automatic observe_frame(input logic [7:0] b, input logic par, input string tag);
    logic [10:0] fb;
    int n, err, fd0, fall0, rx0;
    logic obs_par;
    fb = frame_bits(b);
    n = 0; err = 0; obs_par = 1'bx;
    while (ps2_data !== 1'b0 && n < 200) begin tick(); n++; end
    chk({tag, "_start_timeout"}, (n < 200), 1);
    fd0 = fd_cnt; fall0 = fall_cnt; rx0 = q_rx.size();
    for (int k = 0; k < FRAME_CYC; k++) begin
      if (ps2_data !== fb[k / BIT_CYC] || ps2_clk !== ((k % BIT_CYC) < CLK_DIV) ||
          busy !== 1'b1 || frame_done !== 1'b0) err++;
      if (k == 9 * BIT_CYC + CLK_DIV) obs_par = ps2_data;
      tick();
    end
    chk({tag, "_wave_errs"}, err, 0);
    chk({tag, "_parity"}, obs_par, par);
    chk({tag, "_done_pulse"}, {frame_done, ps2_clk, ps2_data, busy}, 4'b1111);
    err = 0;
    for (int k = 1; k < IDLE_GAP; k++) begin
      tick();
      if (frame_done !== 1'b0 || busy !== 1'b1 || ps2_clk !== 1'b1 || ps2_data !== 1'b1) err++;
    end
    chk({tag, "_gap_errs"}, err, 0);
    tick();
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_falls"}, fall_cnt - fall0, 11);
    chk({tag, "_done_cnt"}, fd_cnt - fd0, 1);
    chk({tag, "_rx_byte"}, (q_rx.size() == rx0 + 1) ? {24'h0, q_rx[rx0]} : 32'hFFFF_FFFF, {24'h0, b});
  endtask

  // Write into an idle transmitter and check minimum latency, then the frame.
  task automatic run_frame(input logic [7:0] b, input logic par, input string tag);
    push(b);
    chk({tag, "_lat1"}, {ps2_data, empty, busy}, 3'b100);
    tick();
    chk({tag, "_lat2"}, {ps2_data, ps2_clk, empty, busy}, 4'b0111);
    observe_frame(b, par, tag);
  endtask

  initial begin : stim
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int sb, fb, rb, n, err, fd0, rx0;

    // Reset state
    tick(); tick(); tick();
    chk("reset_state", {empty, full, overflow, busy, frame_done, ps2_clk, ps2_data}, 7'b1000011);
    resetn = 1'b1;
    tick(); tick();
    chk("post_reset_idle", {empty, busy, ps2_clk, ps2_data}, 4'b1011);

    // Single byte and parity cases
    run_frame(8'h1C, 1'b0, "b1C");
    run_frame(8'h00, 1'b1, "b00");
    run_frame(8'hFF, 1'b1, "bFF");
    run_frame(8'h01, 1'b0, "b01");

    // Burst of two: order and inter-frame spacing
    sb = q_start.size(); fb = q_fd.size(); rb = q_rx.size();
    push(8'hF0);
    push(8'h1C);
    wait_idle("burst", 600);
    chk("burst_count", q_rx.size() - rb, 2);
    chk("burst_order", (q_rx.size() >= rb + 2) ? {16'h0, q_rx[rb], q_rx[rb + 1]} : 32'hFFFF_FFFF,
        32'h0000_F01C);
    chk("burst_gap", (q_start.size() >= sb + 2 && q_fd.size() >= fb + 1) ?
        q_start[sb + 1] - q_fd[fb] : -1, IDLE_GAP + 1);

    // Overflow: one frame in flight, then nine writes with no pop possible
    rb = q_rx.size(); fd0 = fd_cnt;
    exp_q.delete();
    push(8'h11);
    exp_q.push_back(8'h11);
    tick(); tick();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (i < FIFO_DEPTH) exp_q.push_back(b);
      push(b);
      if (i == FIFO_DEPTH - 2) chk("ovf_not_full_7", {full, overflow}, 2'b00);
      if (i == FIFO_DEPTH - 1) chk("ovf_full_8", {full, overflow}, 2'b10);
    end
    chk("ovf_flag_9", {full, overflow}, 2'b11);
    wait_idle("ovf", 9 * (FRAME_CYC + IDLE_GAP + 2) + 100);
    chk("ovf_frames", fd_cnt - fd0, 1 + FIFO_DEPTH);
    err = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (q_rx.size() <= rb + i || q_rx[rb + i] !== exp_q[i]) err++;
    chk("ovf_bytes", err, 0);
    chk("ovf_sticky", overflow, 1'b1);

    // Reset during data bit 4 (clock-low half) with two more bytes queued
    fd0 = fd_cnt; rx0 = q_rx.size();
    push(8'hA5);
    push(8'h3C);
    push(8'h7E);
    for (int k = 1; k < 5 * BIT_CYC + CLK_DIV + 2; k++) tick();
    chk("prerst_lines", {ps2_clk, ps2_data, busy, empty}, 4'b0010);
    #1 resetn = 1'b0;
    #1;
    chk("rst_async", {ps2_clk, ps2_data, empty, full, busy, frame_done, overflow}, 7'b1110000);
    tick(); tick();
    resetn = 1'b1;
    n = 0;
    for (int k = 0; k < 3 * FRAME_CYC; k++) begin
      tick();
      if (ps2_data !== 1'b1 || ps2_clk !== 1'b1 || busy !== 1'b0) n++;
    end
    chk("rst_quiet", n, 0);
    chk("rst_no_done", fd_cnt - fd0, 0);
    chk("rst_no_rx", q_rx.size() - rx0, 0);
    run_frame(8'h5B, 1'b0, "post_rst");

`ifdef PS2_TX_INHIBIT_EN
    // Inhibit during data bit 2, then a full retry of the same byte
    fd0 = fd_cnt;
    push(8'h5A);
    for (int k = 0; k < 3 * BIT_CYC + 2; k++) tick();
    host_inhibit = 1'b1;
    tick(); tick();
    chk("inh_abort", {ps2_clk, ps2_data, busy}, 3'b110);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ps2_data !== 1'b1 || ps2_clk !== 1'b1) n++;
    end
    chk("inh_hold", n, 0);
    chk("inh_no_done", fd_cnt - fd0, 0);
    host_inhibit = 1'b0;
    observe_frame(8'h5A, 1'b1, "inh_retry");
`endif

    // Random bursts checked against the expected byte order and spacing
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(FIFO_DEPTH, 1);
      sb = q_start.size(); fb = q_fd.size(); rb = q_rx.size();
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        push(b);
      end
      wait_idle($sformatf("rnd%0d", r), n * (FRAME_CYC + IDLE_GAP + 2) + 100);
      err = 0;
      for (int i = 0; i < n; i++) begin
        if (q_rx.size() <= rb + i || q_rx[rb + i] !== exp_q[i]) err++;
        if (i > 0 && (q_start.size() <= sb + i || q_fd.size() <= fb + i - 1 ||
                      q_start[sb + i] - q_fd[fb + i - 1] != IDLE_GAP + 1)) err++;
      end
      chk($sformatf("rnd%0d_count", r), q_rx.size() - rb, n);
      chk($sformatf("rnd%0d_bytes_gaps", r), err, 0);
    end

    chk("rx_frame_errors", rx_err, 0);
    chk("final_idle", {empty, busy, ps2_clk, ps2_data}, 4'b1011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
